time_set_ctrl: RTL and testbench

Front-panel control stage that sits directly upstream of the multi-mode clock counter chain. It debounces three raw push-buttons (mode/up/down), runs a mode state machine (run, set hour, set minute, set second), and drives the clock's `en`, `signal_increase[2:0]` and `signal_decrease[2:0]` inputs with single-cycle adjust pulses, including hold-to-repeat. Its `mode` output also feeds the display stage for field blinking.

---
 rtl/time_set_ctrl.sv | 133 +++++++++++++
 tb/tb_time_set_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - button debounce, mode FSM and hold-to-repeat adjust pulses for the clock counter chain
module time_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int REPEAT_DELAY    = 50,
  parameter int REPEAT_RATE     = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       en,
  output logic [2:0] signal_increase,
  output logic [2:0] signal_decrease,
  output logic [1:0] mode
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DELAY_C = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RATE_C  = RW'(REPEAT_RATE);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } mode_t;

  // Button index: 0 = mode, 1 = up, 2 = down
  logic [2:0]         raw, sync1, sync2, lvl, lvl_q, rise;
  logic [2:0][DW-1:0] db_cnt;

  assign raw  = {btn_down, btn_up, btn_mode};
  assign rise = lvl & ~lvl_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      lvl    <= '0;
      lvl_q  <= '0;
      db_cnt <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      lvl_q <= lvl;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          lvl[i]    <= ~lvl[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  mode_t         state;
  logic [2:0]    field;
  logic          rep_on, rep_dn, rep_first, rep_hit, rep_held;
  logic [RW-1:0] rep_cnt;

  always_comb begin
    field = 3'b000;
    case (state)
      SET_HOUR: field = 3'b100;
      SET_MIN:  field = 3'b010;
      SET_SEC:  field = 3'b001;
      default:  field = 3'b000;
    endcase
  end

  // Repeat counter measures from the last emitted pulse of the owning button
  assign rep_hit  = (rep_cnt + RW'(1)) == (rep_first ? DELAY_C : RATE_C);
  assign rep_held = rep_dn ? lvl[2] : lvl[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= RUN;
      en              <= 1'b1;
      signal_increase <= '0;
      signal_decrease <= '0;
      rep_on          <= 1'b0;
      rep_dn          <= 1'b0;
      rep_first       <= 1'b0;
      rep_cnt         <= '0;
    end else begin
      signal_increase <= '0;
      signal_decrease <= '0;
      if (rise[0]) begin
        state   <= mode_t'(state + 2'd1);
        en      <= (state == SET_SEC);
        rep_on  <= 1'b0;
        rep_cnt <= '0;
      end else if ((lvl[1] && lvl[2]) || state == RUN) begin
        rep_on  <= 1'b0;
        rep_cnt <= '0;
      end else if (rise[1]) begin
        signal_increase <= field;
        rep_on    <= 1'b1;
        rep_dn    <= 1'b0;
        rep_first <= 1'b1;
        rep_cnt   <= '0;
      end else if (rise[2]) begin
        signal_decrease <= field;
        rep_on    <= 1'b1;
        rep_dn    <= 1'b1;
        rep_first <= 1'b1;
        rep_cnt   <= '0;
      end else if (rep_on && rep_held) begin
        if (rep_hit) begin
          if (rep_dn) signal_decrease <= field;
          else        signal_increase <= field;
          rep_first <= 1'b0;
          rep_cnt   <= '0;
        end else begin
          rep_cnt <= rep_cnt + RW'(1);
        end
      end else begin
        rep_on  <= 1'b0;
        rep_cnt <= '0;
      end
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - scoreboard bench for time_set_ctrl with directed and random button traffic
module tb_time_set_ctrl;
  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RR = 5;
  localparam int N  = 2600;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic       en;
  logic [2:0] sig_inc, sig_dec;
  logic [1:0] mode;

  always #5 clk = ~clk;

  time_set_ctrl #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .en(en), .signal_increase(sig_inc), .signal_decrease(sig_dec), .mode(mode)
  );

  typedef struct {
    int         edge_no;
    logic [1:0] mode;
    logic [2:0] inc;
    logic [2:0] dec;
  } ev_t;

  ev_t  exp_q[$];
  bit   st_r [N];
  bit   st_m [N];
  bit   st_u [N];
  bit   st_d [N];
  bit   m_s1 [3][N];
  bit   m_s2 [3][N];
  bit   m_d  [3][N];
  int   len_used = 0;
  int   checks = 0, errors = 0;
  int   last_edge = -1;
  bit   done = 0;
  int   s4 = 0, run_lo = 0, run_hi = 0, run_pulses = 0;
  int   dec2_edges[$];
  logic [1:0] prev_mode = 2'd0;

  task automatic put(input bit r, input bit m, input bit u, input bit d, input int len);
    for (int i = 0; i < len; i++) begin
      if (len_used < N) begin
        st_r[len_used] = r; st_m[len_used] = m; st_u[len_used] = u; st_d[len_used] = d;
        len_used++;
      end
    end
  endtask

  task automatic mode_press();
    put(0, 1, 0, 0, 10);
    put(0, 0, 0, 0, 10);
  endtask

  function automatic bit raw_of(input int b, input int t);
    return (b == 0) ? st_m[t] : (b == 1) ? st_u[t] : st_d[t];
  endfunction

  function automatic logic [2:0] fld(input int md);
    logic [2:0] one = 3'b001;
    return one << (3 - md);
  endfunction

  function automatic void push_ev(input int t, input int md, input logic [2:0] i, input logic [2:0] d);
    ev_t x;
    x.edge_no = t; x.mode = 2'(md); x.inc = i; x.dec = d;
    exp_q.push_back(x);
  endfunction

  // Reference: debounced level flips after D consecutive synchronized samples that disagree with it;
  // pulses follow the press / repeat / conflict rules at edge granularity.
  task automatic build_model();
    int run_len [3];
    int md, act, pt, dt;
    bit lu, ld, rm, ru, rdn, held;
    for (int b = 0; b < 3; b++) run_len[b] = 0;
    for (int t = 0; t < N; t++) begin
      for (int b = 0; b < 3; b++) begin
        if (st_r[t] || t == 0) begin
          m_s1[b][t] = 0; m_s2[b][t] = 0; m_d[b][t] = 0; run_len[b] = 0;
        end else begin
          m_s1[b][t] = raw_of(b, t);
          m_s2[b][t] = m_s1[b][t-1];
          m_d[b][t]  = m_d[b][t-1];
          if (m_s2[b][t-1] != m_d[b][t-1]) begin
            run_len[b]++;
            if (run_len[b] == D) begin
              m_d[b][t] = ~m_d[b][t-1];
              run_len[b] = 0;
            end
          end else begin
            run_len[b] = 0;
          end
        end
      end
    end
    md = 0; act = 0; pt = 0;
    for (int t = 0; t < N; t++) begin
      if (st_r[t] || t < 2) begin
        if (md != 0) push_ev(t, 0, 3'b0, 3'b0);
        md = 0; act = 0;
      end else begin
        lu  = m_d[1][t-1];
        ld  = m_d[2][t-1];
        rm  = m_d[0][t-1] && !m_d[0][t-2];
        ru  = lu && !m_d[1][t-2];
        rdn = ld && !m_d[2][t-2];
        held = (act == 1) ? lu : ld;
        if (rm) begin
          md = (md + 1) % 4; act = 0;
          push_ev(t, md, 3'b0, 3'b0);
        end else if ((lu && ld) || md == 0) begin
          act = 0;
        end else if (ru) begin
          push_ev(t, md, fld(md), 3'b0); act = 1; pt = t;
        end else if (rdn) begin
          push_ev(t, md, 3'b0, fld(md)); act = 2; pt = t;
        end else if (act != 0 && held) begin
          dt = t - pt;
          if (dt == RD || (dt > RD && (dt - RD) % RR == 0)) begin
            if (act == 1) push_ev(t, md, fld(md), 3'b0);
            else          push_ev(t, md, 3'b0, fld(md));
          end
        end else begin
          act = 0;
        end
      end
    end
  endtask

  initial begin
    int len;
    int want [6];
    // Reset with buttons high, then idle
    put(1, 1, 1, 1, 2);
    put(0, 0, 0, 0, 20);
    // Mode cycling: 1, 2, 3, 0
    repeat (4) mode_press();
    // Single adjust in SET_MIN
    repeat (2) mode_press();
    put(0, 0, 1, 0, 10);
    put(0, 0, 0, 0, 20);
    // Auto-repeat in SET_HOUR
    repeat (3) mode_press();
    s4 = len_used;
    put(0, 0, 0, 1, 45);
    put(0, 0, 0, 0, 25);
    // Up held across a mode change: SET_HOUR pulse, nothing in SET_MIN
    put(0, 0, 1, 0, 15);
    put(0, 1, 1, 0, 10);
    put(0, 0, 1, 0, 30);
    put(0, 0, 0, 0, 15);
    mode_press();
    // SET_SEC: short glitch, then simultaneous up+down
    put(0, 0, 1, 0, 3);
    put(0, 0, 0, 0, 10);
    put(0, 0, 1, 1, 15);
    put(0, 0, 0, 0, 15);
    mode_press();
    // RUN: long up hold ignored
    run_lo = len_used;
    put(0, 0, 1, 0, 50);
    put(0, 0, 0, 0, 15);
    run_hi = len_used - 1;
    // Reset while holding down in SET_HOUR
    mode_press();
    put(0, 0, 0, 1, 30);
    put(1, 0, 0, 1, 2);
    put(0, 0, 0, 1, 20);
    put(0, 0, 0, 0, 15);
    while (len_used < N - 40) begin
      if ($urandom_range(0, 60) == 0) begin
        put(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(1, 2));
      end else begin
        len = $urandom_range(1, 40);
        put(0, $urandom_range(0, 3) == 0, $urandom_range(0, 1), $urandom_range(0, 2) == 0, len);
      end
    end
    build_model();

    for (int t = 0; t < N; t++) begin
      rst = st_r[t]; btn_mode = st_m[t]; btn_up = st_u[t]; btn_down = st_d[t];
      @(posedge clk);
      last_edge = t;
      #1;
    end
    @(negedge clk);
    #1;
    done = 1;

    while (exp_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL missing_event: got no event, expected edge=%0d mode=%0d inc=%b dec=%b",
               exp_q[0].edge_no, exp_q[0].mode, exp_q[0].inc, exp_q[0].dec);
      void'(exp_q.pop_front());
    end
    want = '{6, 26, 31, 36, 41, 46};
    checks++;
    if (dec2_edges.size() != 6) begin
      errors++;
      $display("FAIL repeat_count: got %0d pulses on signal_decrease[2], expected 6", dec2_edges.size());
    end
    for (int i = 0; i < 6 && i < dec2_edges.size(); i++) begin
      checks++;
      if (dec2_edges[i] != s4 + want[i]) begin
        errors++;
        $display("FAIL repeat_time[%0d]: got press+%0d, expected press+%0d", i, dec2_edges[i] - s4, want[i]);
      end
    end
    checks++;
    if (run_pulses != 0) begin
      errors++;
      $display("FAIL run_hold: got %0d adjust pulses in RUN, expected 0", run_pulses);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int  e;
    ev_t x;
    forever begin
      @(negedge clk);
      if (last_edge >= 0 && !done) begin
        e = last_edge;
        checks++;
        if (en != (mode == 2'd0) || $countones({sig_inc, sig_dec}) > 1) begin
          errors++;
          $display("FAIL invariant@%0d: got en=%0d mode=%0d inc=%b dec=%b, expected en==(mode==0) and <=1 adjust bit",
                   e, en, mode, sig_inc, sig_dec);
        end
        if (e <= 21) begin
          checks++;
          if (mode != 2'd0 || en != 1'b1 || sig_inc != 3'b0 || sig_dec != 3'b0) begin
            errors++;
            $display("FAIL reset@%0d: got mode=%0d en=%0d inc=%b dec=%b, expected mode=0 en=1 inc=000 dec=000",
                     e, mode, en, sig_inc, sig_dec);
          end
        end
        while (exp_q.size() > 0 && exp_q[0].edge_no < e) begin
          checks++; errors++;
          $display("FAIL missed_event@%0d: nothing seen, expected mode=%0d inc=%b dec=%b",
                   exp_q[0].edge_no, exp_q[0].mode, exp_q[0].inc, exp_q[0].dec);
          void'(exp_q.pop_front());
        end
        if (mode != prev_mode || sig_inc != 3'b0 || sig_dec != 3'b0) begin
          checks++;
          if (exp_q.size() == 0 || exp_q[0].edge_no != e) begin
            errors++;
            $display("FAIL unexpected_event@%0d: got mode=%0d inc=%b dec=%b, expected no change",
                     e, mode, sig_inc, sig_dec);
          end else begin
            x = exp_q.pop_front();
            if (mode != x.mode || sig_inc != x.inc || sig_dec != x.dec || en != (x.mode == 2'd0)) begin
              errors++;
              $display("FAIL event@%0d: got mode=%0d en=%0d inc=%b dec=%b, expected mode=%0d en=%0d inc=%b dec=%b",
                       e, mode, en, sig_inc, sig_dec, x.mode, (x.mode == 2'd0), x.inc, x.dec);
            end
          end
        end
        if (sig_dec[2] && e >= s4 && e < s4 + 80) dec2_edges.push_back(e);
        if (e >= run_lo && e <= run_hi && (sig_inc != 3'b0 || sig_dec != 3'b0)) run_pulses++;
        prev_mode = mode;
      end
    end
  end

endmodule
